ss_ddram_bridge: RTL



---
 rtl/ss_ddram_bridge_if.sv | 29 ++
 rtl/ss_ddram_bridge.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/ss_ddram_bridge_if.sv
// ---------------------------------------------------------------------------
// ss_ddram_bridge_if: savestate toggle-handshake DDR request/response bundle.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface ss_ddram_bridge_if;
  logic        req;
  logic        ack;
  logic [18:0] addr;
  logic        we;
  logic [7:0]  be;
  logic [63:0] wdata;
  logic [63:0] rdata;
  logic        inval;
  logic        err;

  modport master (
    output req, addr, we, be, wdata, inval,
    input  ack, rdata, err
  );

  modport slave (
    input  req, addr, we, be, wdata, inval,
    output ack, rdata, err
  );
endinterface

`default_nettype wire

// File: rtl/ss_ddram_bridge.sv
// ---------------------------------------------------------------------------
// ss_ddram_bridge: toggle-handshake to MiSTer DDRAM Avalon bridge, one-line read cache.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ss_ddram_bridge #(
  parameter logic [9:0]  BASE_HI = 10'h3F8,
  parameter int unsigned TIMEOUT = 4095
) (
  input  wire logic         clk,
  input  wire logic         reset_n,
  ss_ddram_bridge_if.slave  hs,
  output logic [28:0]       ddram_addr_o,
  output logic [7:0]        ddram_burstcnt_o,
  output logic              ddram_rd_o,
  output logic              ddram_we_o,
  output logic [7:0]        ddram_be_o,
  output logic [63:0]       ddram_din_o,
  input  wire logic [63:0]  ddram_dout_i,
  input  wire logic         ddram_dout_ready_i,
  input  wire logic         ddram_busy_i
);

  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WR      = 2'd1,
    S_RD      = 2'd2,
    S_RD_DATA = 2'd3
  } state_t;

  state_t      state_q;
  logic        ack_q;
  logic [63:0] rdata_q;
  logic        err_q;
  logic        rd_q;
  logic        we_q;
  logic [28:0] addr_q;
  logic [7:0]  be_q;
  logic [63:0] din_q;
  logic        valid_q;
  logic [18:0] tag_q;
  logic [63:0] line_q;
  logic [15:0] cnt_q;

  logic [63:0] line_merge_d;
  logic [15:0] cnt_d;
  logic        hit_d;
  logic        wr_tag_match_d;

  // An inval in the same cycle as a would-be hit forces the miss path.
  assign hit_d          = valid_q && (tag_q == hs.addr) && !hs.inval;
  assign wr_tag_match_d = valid_q && (tag_q == addr_q[18:0]);
  assign cnt_d          = cnt_q + 16'd1;

  always_comb begin
    line_merge_d = line_q;
    for (int i = 0; i < 8; i++) begin
      if (be_q[i]) line_merge_d[8*i +: 8] = din_q[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ack_q   <= 1'b0;
      rdata_q <= 64'd0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 29'd0;
      be_q    <= 8'hFF;
      din_q   <= 64'd0;
      valid_q <= 1'b0;
      tag_q   <= 19'd0;
      line_q  <= 64'd0;
      cnt_q   <= 16'd0;
    end else begin
      if (hs.inval) begin
        valid_q <= 1'b0;
        err_q   <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (hs.req != ack_q) begin
            addr_q <= {BASE_HI, hs.addr};
            be_q   <= hs.be;
            din_q  <= hs.wdata;
            if (hs.we) begin
              we_q    <= 1'b1;
              state_q <= S_WR;
            end else if (hit_d) begin
              rdata_q <= line_q;
              ack_q   <= hs.req;
            end else begin
              rd_q    <= 1'b1;
              state_q <= S_RD;
            end
          end
        end

        S_WR: begin
          if (!ddram_busy_i) begin
            we_q    <= 1'b0;
            ack_q   <= ~ack_q;
            state_q <= S_IDLE;
            // Write-through keeps the cached line coherent with DDR.
            if (wr_tag_match_d) line_q <= line_merge_d;
          end
        end

        S_RD: begin
          if (!ddram_busy_i) begin
            rd_q    <= 1'b0;
            cnt_q   <= 16'd0;
            state_q <= S_RD_DATA;
          end
        end

        S_RD_DATA: begin
          if (ddram_dout_ready_i) begin
            rdata_q <= ddram_dout_i;
            line_q  <= ddram_dout_i;
            tag_q   <= addr_q[18:0];
            valid_q <= !hs.inval;
            ack_q   <= ~ack_q;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_d;
            if (cnt_d == TIMEOUT_C) begin
              rdata_q <= 64'd0;
              err_q   <= 1'b1;
              valid_q <= 1'b0;
              ack_q   <= ~ack_q;
              state_q <= S_IDLE;
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign hs.ack           = ack_q;
  assign hs.rdata         = rdata_q;
  assign hs.err           = err_q;
  assign ddram_addr_o     = addr_q;
  assign ddram_burstcnt_o = 8'd1;
  assign ddram_rd_o       = rd_q;
  assign ddram_we_o       = we_q;
  assign ddram_be_o       = be_q;
  assign ddram_din_o      = din_q;

endmodule

`default_nettype wire
